core_run_monitor: RTL and testbench
===================================

CORE_RUN_MONITOR -- requirements
Module: core_run_monitor

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of monitored program counter.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of cycle counter and cycle limit.
REQ-003 SHALL have parameter TRACE_DEPTH, default 8, trace FIFO entries; power of two, >=2.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle pulse; begins a monitored run.
REQ-007 SHALL have port expected_pc  input  PC_WIDTH  halt PC required for pass; sampled on accepted start.
REQ-008 SHALL have port cycle_limit  input  CNT_WIDTH  run timeout in cycles; 0 = no limit; sampled on accepted start.
REQ-009 SHALL have port current_pc  input  PC_WIDTH  core PC under observation.
REQ-010 SHALL have port halted  input  1  core halt indication.
REQ-011 SHALL have port trace_pop  input  1  consumer pops head trace entry when trace_valid.
REQ-012 SHALL have port trace_valid  output  1  trace FIFO non-empty.
REQ-013 SHALL have port trace_pc  output  PC_WIDTH  PC of head entry.
REQ-014 SHALL have port trace_cycle  output  CNT_WIDTH  cycle_count value at which head entry was recorded.
REQ-015 SHALL have port trace_overflow  output  1  sticky; an entry was dropped this run.
REQ-016 SHALL have port busy  output  1  high in RUN.
REQ-017 SHALL have port done  output  1  high in DONE.
REQ-018 SHALL have port result  output  2  00 none, 01 pass, 10 partial (halted, wrong PC), 11 fail (timeout).
REQ-019 SHALL have port cycle_count  output  CNT_WIDTH  cycles elapsed in current/last run.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DONE.
REQ-021 IDLE/DONE + start: SHALL latch expected_pc, cycle_limit; clear cycle_count, FIFO, trace_overflow, result; set prev_pc to all ones; enter RUN next cycle.
REQ-022 start while in RUN SHALL be ignored.
REQ-023 In RUN, cycle_count SHALL increment by 1 each cycle, saturating at all ones.
REQ-024 In RUN, when current_pc != prev_pc, SHALL push {current_pc, cycle_count (pre-increment value)} and update prev_pc to current_pc, same cycle.
REQ-025 In RUN with halted=1: SHALL enter DONE next cycle; result=01 if current_pc==latched expected_pc, else 10; PC-change push of that cycle still occurs.
REQ-026 In RUN with halted=0, latched limit L!=0 and cycle_count==L-1: SHALL enter DONE with result=11.
REQ-027 halted and timeout same cycle: halt SHALL take priority.
REQ-028 In DONE, cycle_count, result and prev_pc SHALL hold; no pushes; FIFO remains poppable.
REQ-029 Push when FIFO full and no pop same cycle: entry SHALL be dropped, trace_overflow set; existing entries unchanged.
REQ-030 Push and pop same cycle when full: both SHALL occur; no overflow.
REQ-031 Pop when empty SHALL be ignored; push into empty FIFO SHALL appear on trace outputs next cycle.
REQ-032 FIFO pointers SHALL wrap modulo TRACE_DEPTH; order strictly first-in first-out.
REQ-033 trace_pop SHALL be honoured in all states.

Reset
REQ-034 rst SHALL force IDLE, busy=0, done=0, result=00, cycle_count=0, trace_valid=0, trace_overflow=0, prev_pc=all ones, FIFO empty.
REQ-035 rst SHALL override start, halted and trace_pop in the same cycle, including mid-run.
REQ-036 trace_pc/trace_cycle SHALL be don't-care while trace_valid=0.

Verification
REQ-037 start, expected_pc=0x04, limit=50; PC 0x00,0x00,0x02,0x02,0x04 with halted at 0x04 -> pass (01), trace {0x00,0},{0x02,2},{0x04,4}, done=1.
REQ-038 start, expected_pc=0x04, limit=50; halt at PC 0x06 -> result=10, done=1.
REQ-039 start, limit=10, halted never asserts -> DONE with result=11 after 10 RUN cycles, cycle_count=10.
REQ-040 TRACE_DEPTH=8, PC changes every cycle for 12 cycles, no pops -> 8 entries (PCs of first 8 changes), trace_overflow=1.
REQ-041 halted asserted on cycle_count==L-1 -> result pass/partial, not fail.
REQ-042 rst asserted mid-run with 3 entries queued -> all outputs at REQ-034 values next cycle; subsequent start runs normally.

Source files
------------

// File: rtl/core_run_monitor.sv
// Run monitor: times a core run from start to halt or timeout, grades the halt PC
// against an expected value, and records PC changes into a small trace FIFO.
module core_run_monitor #(
  parameter int PC_WIDTH    = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  expected_pc,
  input  logic [CNT_WIDTH-1:0] cycle_limit,
  input  logic [PC_WIDTH-1:0]  current_pc,
  input  logic                 halted,
  input  logic                 trace_pop,
  output logic                 trace_valid,
  output logic [PC_WIDTH-1:0]  trace_pc,
  output logic [CNT_WIDTH-1:0] trace_cycle,
  output logic                 trace_overflow,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           result,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int AW = $clog2(TRACE_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_PASS    = 2'b01;
  localparam logic [1:0] RES_PARTIAL = 2'b10;
  localparam logic [1:0] RES_FAIL    = 2'b11;

  localparam logic [AW:0]          FULL_LVL = (AW+1)'(TRACE_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [1:0]           state_q,  state_d;
  logic [PC_WIDTH-1:0]  exp_pc_q, exp_pc_d;
  logic [CNT_WIDTH-1:0] limit_q,  limit_d;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic [1:0]           result_q, result_d;
  logic [PC_WIDTH-1:0]  prev_pc_q, prev_pc_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level_q,  level_d;
  logic                 ovf_q,    ovf_d;

  logic [PC_WIDTH-1:0]  pc_mem_q  [TRACE_DEPTH];
  logic [CNT_WIDTH-1:0] cyc_mem_q [TRACE_DEPTH];

  logic clear_fifo_s;
  logic push_req_s;
  logic push_ok_s;
  logic pop_ok_s;

  // Run control FSM: start acceptance, cycle counting, halt/timeout grading
  always_comb begin
    state_d      = state_q;
    exp_pc_d     = exp_pc_q;
    limit_d      = limit_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    prev_pc_d    = prev_pc_q;
    clear_fifo_s = 1'b0;
    push_req_s   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          exp_pc_d     = expected_pc;
          limit_d      = cycle_limit;
          cnt_d        = {CNT_WIDTH{1'b0}};
          result_d     = RES_NONE;
          prev_pc_d    = {PC_WIDTH{1'b1}};
          clear_fifo_s = 1'b1;
          state_d      = S_RUN;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (cnt_q != {CNT_WIDTH{1'b1}}) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        if (current_pc != prev_pc_q) begin
          push_req_s = 1'b1;
          prev_pc_d  = current_pc;
        end else begin
          push_req_s = 1'b0;
        end
        // Halt outranks a timeout landing on the same cycle
        if (halted) begin
          state_d  = S_DONE;
          result_d = (current_pc == exp_pc_q) ? RES_PASS : RES_PARTIAL;
        end else if ((limit_q != {CNT_WIDTH{1'b0}}) && (cnt_q == (limit_q - CNT_ONE))) begin
          state_d  = S_DONE;
          result_d = RES_FAIL;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Trace FIFO bookkeeping; a pop frees room for a push in the same cycle
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    pop_ok_s  = trace_pop && (level_q != {(AW+1){1'b0}});
    push_ok_s = push_req_s && ((level_q != FULL_LVL) || pop_ok_s);
    if (clear_fifo_s) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {(AW+1){1'b0}};
      ovf_d    = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      level_d = level_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
      if (push_req_s && !push_ok_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Control and FIFO pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      exp_pc_q  <= {PC_WIDTH{1'b0}};
      limit_q   <= {CNT_WIDTH{1'b0}};
      cnt_q     <= {CNT_WIDTH{1'b0}};
      result_q  <= RES_NONE;
      prev_pc_q <= {PC_WIDTH{1'b1}};
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      level_q   <= {(AW+1){1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_pc_q  <= exp_pc_d;
      limit_q   <= limit_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      prev_pc_q <= prev_pc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  // Trace storage; contents are meaningless until the pointers cover them
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) begin
      pc_mem_q[wr_ptr_q]  <= current_pc;
      cyc_mem_q[wr_ptr_q] <= cnt_q;
    end
  end

  assign trace_valid    = (level_q != {(AW+1){1'b0}});
  assign trace_pc       = pc_mem_q[rd_ptr_q];
  assign trace_cycle    = cyc_mem_q[rd_ptr_q];
  assign trace_overflow = ovf_q;
  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign result         = result_q;
  assign cycle_count    = cnt_q;

endmodule

// File: tb/tb_core_run_monitor.sv
// Directed bench for core_run_monitor: pass/partial/timeout grading, trace FIFO
// order, overflow, full push+pop, limit edge and mid-run reset.
module tb_core_run_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] expected_pc;
  logic [31:0] cycle_limit;
  logic [31:0] current_pc;
  logic        halted;
  logic        trace_pop;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_cycle;
  logic        trace_overflow;
  logic        busy;
  logic        done;
  logic [1:0]  result;
  logic [31:0] cycle_count;

  int vectors = 0;
  int miscompares = 0;

  core_run_monitor #(.PC_WIDTH(32), .CNT_WIDTH(32), .TRACE_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .expected_pc(expected_pc),
    .cycle_limit(cycle_limit), .current_pc(current_pc), .halted(halted),
    .trace_pop(trace_pop), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_cycle(trace_cycle), .trace_overflow(trace_overflow), .busy(busy),
    .done(done), .result(result), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [31:0] pc, input logic h, input logic pop);
    current_pc = pc; halted = h; trace_pop = pop;
    @(posedge clk); #1;
    start = 1'b0; halted = 1'b0; trace_pop = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] exp_pc, input logic [31:0] lim);
    start = 1'b1; expected_pc = exp_pc; cycle_limit = lim;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    vectors++;
    if ({busy, done, result, trace_valid, trace_overflow} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 000000", {busy, done, result, trace_valid, trace_overflow});
    end
    vectors++;
    if (cycle_count !== 32'd0) begin
      miscompares++; $display("FAIL reset_count got %0d want 0", cycle_count);
    end
  endtask

  task automatic test_pass();
    logic [31:0] pcs [5] = '{32'h00, 32'h00, 32'h02, 32'h02, 32'h04};
    logic [31:0] epc [3] = '{32'h00, 32'h02, 32'h04};
    logic [31:0] ecy [3] = '{32'd0, 32'd2, 32'd4};
    do_start(32'h04, 32'd50);
    vectors++;
    if (busy !== 1'b1 || cycle_count !== 32'd0) begin
      miscompares++; $display("FAIL pass_enter_run got busy=%b cnt=%0d want busy=1 cnt=0", busy, cycle_count);
    end
    for (int i = 0; i < 5; i++) step(pcs[i], (i == 4), 1'b0);
    vectors++;
    if ({busy, done, result} !== 4'b0101 || cycle_count !== 32'd5) begin
      miscompares++;
      $display("FAIL pass_result got b/d/r=%b cnt=%0d want 0101 cnt=5", {busy, done, result}, cycle_count);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (trace_valid !== 1'b1 || trace_pc !== epc[i] || trace_cycle !== ecy[i]) begin
        miscompares++;
        $display("FAIL pass_trace%0d got v=%b pc=%h cyc=%0d want v=1 pc=%h cyc=%0d",
                 i, trace_valid, trace_pc, trace_cycle, epc[i], ecy[i]);
      end
      step(32'h77, 1'b0, 1'b1);
    end
    vectors++;
    if (trace_valid !== 1'b0 || done !== 1'b1) begin
      miscompares++; $display("FAIL pass_drained got v=%b done=%b want v=0 done=1", trace_valid, done);
    end
  endtask

  task automatic test_partial();
    do_start(32'h04, 32'd50);
    step(32'h06, 1'b1, 1'b0);
    vectors++;
    if ({busy, done, result} !== 4'b0110 || cycle_count !== 32'd1) begin
      miscompares++;
      $display("FAIL partial_result got b/d/r=%b cnt=%0d want 0110 cnt=1", {busy, done, result}, cycle_count);
    end
    vectors++;
    if (trace_valid !== 1'b1 || trace_pc !== 32'h06 || trace_cycle !== 32'd0) begin
      miscompares++;
      $display("FAIL partial_trace got v=%b pc=%h cyc=%0d want v=1 pc=06 cyc=0", trace_valid, trace_pc, trace_cycle);
    end
  endtask

  task automatic test_timeout();
    do_start(32'h04, 32'd10);
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin
        start = 1'b1; cycle_limit = 32'd3;
      end
      step(32'h100, 1'b0, 1'b0);
    end
    vectors++;
    if (busy !== 1'b1 || cycle_count !== 32'd9) begin
      miscompares++; $display("FAIL timeout_before got busy=%b cnt=%0d want busy=1 cnt=9", busy, cycle_count);
    end
    step(32'h100, 1'b0, 1'b0);
    vectors++;
    if ({busy, done, result} !== 4'b0111 || cycle_count !== 32'd10) begin
      miscompares++;
      $display("FAIL timeout_result got b/d/r=%b cnt=%0d want 0111 cnt=10", {busy, done, result}, cycle_count);
    end
    for (int i = 0; i < 3; i++) step(32'h200 + i, 1'b1, 1'b0);
    vectors++;
    if ({done, result} !== 3'b111 || cycle_count !== 32'd10) begin
      miscompares++;
      $display("FAIL timeout_hold got d/r=%b cnt=%0d want 111 cnt=10", {done, result}, cycle_count);
    end
    vectors++;
    if (trace_valid !== 1'b1 || trace_pc !== 32'h100 || trace_cycle !== 32'd0) begin
      miscompares++;
      $display("FAIL timeout_trace got v=%b pc=%h cyc=%0d want v=1 pc=100 cyc=0", trace_valid, trace_pc, trace_cycle);
    end
    step(32'h0, 1'b0, 1'b1);
    vectors++;
    if (trace_valid !== 1'b0) begin
      miscompares++; $display("FAIL timeout_no_push_in_done got v=%b want 0", trace_valid);
    end
  endtask

  task automatic test_overflow();
    do_start(32'h1B, 32'd0);
    for (int i = 0; i < 12; i++) step(32'h10 + i, 1'b0, 1'b0);
    vectors++;
    if (busy !== 1'b1 || trace_overflow !== 1'b1 || cycle_count !== 32'd12) begin
      miscompares++;
      $display("FAIL ovf_state got busy=%b ovf=%b cnt=%0d want 1 1 12", busy, trace_overflow, cycle_count);
    end
    step(32'h1B, 1'b1, 1'b0);
    vectors++;
    if ({done, result} !== 3'b101 || cycle_count !== 32'd13) begin
      miscompares++; $display("FAIL ovf_result got d/r=%b cnt=%0d want 101 cnt=13", {done, result}, cycle_count);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (trace_valid !== 1'b1 || trace_pc !== (32'h10 + i) || trace_cycle !== i) begin
        miscompares++;
        $display("FAIL ovf_trace%0d got v=%b pc=%h cyc=%0d want v=1 pc=%h cyc=%0d",
                 i, trace_valid, trace_pc, trace_cycle, 32'h10 + i, i);
      end
      step(32'h0, 1'b0, 1'b1);
    end
    vectors++;
    if (trace_valid !== 1'b0) begin
      miscompares++; $display("FAIL ovf_drained got v=%b want 0", trace_valid);
    end
  endtask

  task automatic test_full_pop();
    do_start(32'h99, 32'd0);
    for (int i = 0; i < 8; i++) step(32'h20 + i, 1'b0, 1'b0);
    step(32'h28, 1'b0, 1'b1);
    vectors++;
    if (trace_overflow !== 1'b0 || trace_pc !== 32'h21 || trace_cycle !== 32'd1) begin
      miscompares++;
      $display("FAIL fullpop_head got ovf=%b pc=%h cyc=%0d want ovf=0 pc=21 cyc=1", trace_overflow, trace_pc, trace_cycle);
    end
    step(32'h28, 1'b1, 1'b0);
    vectors++;
    if ({done, result} !== 3'b110) begin
      miscompares++; $display("FAIL fullpop_result got d/r=%b want 110", {done, result});
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (trace_valid !== 1'b1 || trace_pc !== (32'h21 + i) || trace_cycle !== (i + 1)) begin
        miscompares++;
        $display("FAIL fullpop_trace%0d got v=%b pc=%h cyc=%0d want v=1 pc=%h cyc=%0d",
                 i, trace_valid, trace_pc, trace_cycle, 32'h21 + i, i + 1);
      end
      step(32'h0, 1'b0, 1'b1);
    end
    vectors++;
    if (trace_valid !== 1'b0) begin
      miscompares++; $display("FAIL fullpop_drained got v=%b want 0", trace_valid);
    end
  endtask

  task automatic test_limit_edge();
    do_start(32'h40, 32'd3);
    step(32'h40, 1'b0, 1'b0);
    step(32'h40, 1'b0, 1'b0);
    step(32'h40, 1'b1, 1'b0);
    vectors++;
    if ({done, result} !== 3'b101 || cycle_count !== 32'd3) begin
      miscompares++; $display("FAIL limit_edge got d/r=%b cnt=%0d want 101 cnt=3", {done, result}, cycle_count);
    end
  endtask

  task automatic test_reset_midrun();
    do_start(32'h04, 32'd0);
    step(32'h1, 1'b0, 1'b0);
    step(32'h2, 1'b0, 1'b0);
    step(32'h3, 1'b0, 1'b0);
    rst = 1'b1; start = 1'b1;
    step(32'h7, 1'b1, 1'b1);
    rst = 1'b0;
    vectors++;
    if ({busy, done, result, trace_valid, trace_overflow} !== 6'b000000 || cycle_count !== 32'd0) begin
      miscompares++;
      $display("FAIL midrun_reset got flags=%b cnt=%0d want 000000 cnt=0",
               {busy, done, result, trace_valid, trace_overflow}, cycle_count);
    end
    do_start(32'h08, 32'd0);
    step(32'h08, 1'b1, 1'b0);
    vectors++;
    if ({done, result} !== 3'b101 || cycle_count !== 32'd1 || trace_pc !== 32'h08 || trace_cycle !== 32'd0) begin
      miscompares++;
      $display("FAIL midrun_rerun got d/r=%b cnt=%0d pc=%h cyc=%0d want 101 1 08 0",
               {done, result}, cycle_count, trace_pc, trace_cycle);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; expected_pc = 32'h0; cycle_limit = 32'h0;
    current_pc = 32'h0; halted = 1'b0; trace_pop = 1'b0;
    test_reset();
    test_pass();
    test_partial();
    test_timeout();
    test_overflow();
    test_full_pop();
    test_limit_edge();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
